// File: rtl/frame_status_pkg.sv
// ---------------------------------------------------------------------------
// frame_status_pkg
// Shared definitions for the frame status monitor:
//   - register read addresses
//   - event entry layout (16-bit frame index, 3-bit status)
//   - bit positions of the event pop word and the status register
//   - helper that packs a popped entry into the 32-bit read word
// ---------------------------------------------------------------------------
package frame_status_pkg;

    localparam logic [2:0] REG_FRAME_CNT = 3'd0;
    localparam logic [2:0] REG_ERR2_CNT  = 3'd1;
    localparam logic [2:0] REG_ERR1_CNT  = 3'd2;
    localparam logic [2:0] REG_SEQ_CNT   = 3'd3;
    localparam logic [2:0] REG_STATUS    = 3'd4;
    localparam logic [2:0] REG_EVT_POP   = 3'd5;

    localparam int EVT_IDX_W  = 16;
    localparam int EVT_STAT_W = 3;
    localparam int EVT_W      = EVT_IDX_W + EVT_STAT_W;

    // Pop word: {valid, 12'b0, status[2:0], index[15:0]}
    localparam int POP_VALID_BIT = 31;
    localparam int POP_STAT_LSB  = 16;
    localparam int POP_IDX_LSB   = 0;

    // Status register: {overflow, zeros, fifo level}
    localparam int STATUS_OVF_BIT = 31;

    typedef struct packed {
        logic [EVT_STAT_W-1:0] status;
        logic [EVT_IDX_W-1:0]  index;
    } evt_entry_t;

    // An invalid pop returns an all-zero word so stale memory never leaks out.
    function automatic logic [31:0] pack_pop_word(input logic valid, input evt_entry_t e);
        logic [31:0] w;
        w = '0;
        if (valid) begin
            w[POP_VALID_BIT]                          = 1'b1;
            w[POP_STAT_LSB +: EVT_STAT_W]             = e.status;
            w[POP_IDX_LSB +: EVT_IDX_W]               = e.index;
        end
        return w;
    endfunction

endpackage

// File: rtl/status_event_fifo.sv
// ---------------------------------------------------------------------------
// status_event_fifo
// Synchronous first-word-fall-through FIFO for event records.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, din     write request and data (ignored when full unless popping)
//   pop           read request (ignored when empty)
//   dout          head entry, valid whenever empty is low
//   full, empty   occupancy flags
//   level         number of stored entries (0 .. 2^DEPTH_LOG2)
// ---------------------------------------------------------------------------
module status_event_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   LVL_MAX = DEPTH[DEPTH_LOG2:0];

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty = (level == '0);
    assign full  = (level == LVL_MAX);

    // A pop in the same cycle frees a slot, so a push into a full FIFO succeeds.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign dout = mem[rd_ptr];

    // Storage carries no reset; the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                level <= level + LVL_ONE;
            end else if (do_pop && !do_push) begin
                level <= level - LVL_ONE;
            end
        end
    end

endmodule

// File: rtl/frame_status_monitor.sv
// ---------------------------------------------------------------------------
// frame_status_monitor
// Turns per-frame status bytes into counters, an event queue and an
// interrupt, readable through a single-cycle register port.
// Ports:
//   aclk, areset                 clock, asynchronous active-high reset
//   s_axis_tdata/tvalid/tready   status byte stream; bits [2:0] used
//   clear_counts                 pulse: zero counters and overflow sticky
//   reg_addr, reg_rd             read address and one-cycle read strobe
//   reg_rdata, reg_rvalid        read data (held) and one-cycle valid
//   irq                          level interrupt: events pending or overflow
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high; tready is high from the first edge after reset and never drops.
// ---------------------------------------------------------------------------
module frame_status_monitor
    import frame_status_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        clear_counts,
    input  logic [2:0]  reg_addr,
    input  logic        reg_rd,
    output logic [31:0] reg_rdata,
    output logic        reg_rvalid,
    output logic        irq
);

    logic [31:0]            frame_count;
    logic [CNT_WIDTH-1:0]   err2_cnt;
    logic [CNT_WIDTH-1:0]   err1_cnt;
    logic [CNT_WIDTH-1:0]   seq_cnt;
    logic                   overflow;

    logic [2:0]             status;
    logic                   beat;
    logic                   evt_push;
    logic                   evt_pop;
    evt_entry_t             evt_in;
    evt_entry_t             evt_head;
    logic [EVT_W-1:0]       fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] fifo_level;
    logic [31:0]            rd_mux;
    logic                   unused_bits;

    assign unused_bits = ^s_axis_tdata[7:3];

    assign status   = s_axis_tdata[2:0];
    assign beat     = s_axis_tvalid & s_axis_tready;
    assign evt_push = beat & (status != 3'b000);
    assign evt_pop  = reg_rd & (reg_addr == REG_EVT_POP);

    // Index is the frame count before this beat's increment.
    assign evt_in.status = status;
    assign evt_in.index  = frame_count[EVT_IDX_W-1:0];
    assign evt_head      = evt_entry_t'(fifo_dout);

    status_event_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (EVT_W)
    ) u_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (evt_push),
        .din   (evt_in),
        .pop   (evt_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                    input logic en);
        logic [CNT_WIDTH-1:0] one;
        one = 1;
        if (en && (v != '1)) begin
            return v + one;
        end
        return v;
    endfunction

    // Read mux reflects state before any update on the same edge.
    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            REG_FRAME_CNT: rd_mux = frame_count;
            REG_ERR2_CNT:  rd_mux = 32'(err2_cnt);
            REG_ERR1_CNT:  rd_mux = 32'(err1_cnt);
            REG_SEQ_CNT:   rd_mux = 32'(seq_cnt);
            REG_STATUS: begin
                rd_mux[FIFO_DEPTH_LOG2:0] = fifo_level;
                rd_mux[STATUS_OVF_BIT]    = overflow;
            end
            REG_EVT_POP:   rd_mux = pack_pop_word(~fifo_empty, evt_head);
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s_axis_tready <= 1'b0;
            reg_rdata     <= '0;
            reg_rvalid    <= 1'b0;
            irq           <= 1'b0;
            frame_count   <= '0;
            err2_cnt      <= '0;
            err1_cnt      <= '0;
            seq_cnt       <= '0;
            overflow      <= 1'b0;
        end else begin
            s_axis_tready <= 1'b1;
            reg_rvalid    <= reg_rd;
            if (reg_rd) begin
                reg_rdata <= rd_mux;
            end
            irq <= ~fifo_empty | overflow;

            // Clear wins over a same-cycle beat; the beat's FIFO push is unaffected.
            if (clear_counts) begin
                frame_count <= '0;
                err2_cnt    <= '0;
                err1_cnt    <= '0;
                seq_cnt     <= '0;
            end else if (beat) begin
                frame_count <= frame_count + 32'd1;
                err2_cnt    <= sat_inc(err2_cnt, status[2]);
                err1_cnt    <= sat_inc(err1_cnt, status[1]);
                seq_cnt     <= sat_inc(seq_cnt,  status[0]);
            end

            if (clear_counts) begin
                overflow <= 1'b0;
            end else if (evt_push && fifo_full && !(evt_pop && !fifo_empty)) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
